// File: rtl/leading_ones_count.sv
`default_nettype none
// ============================================================================
// Module   : leading_ones_count
// Purpose  : Counts the contiguous run of ones starting at bit 0. Used to
//            turn per-lane valid/ready vectors into an in-order lane count.
// Revision : 1.0 - initial release
// ============================================================================
module leading_ones_count #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]             bits,
  output logic [$clog2(WIDTH+1)-1:0]   ones
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  logic w_run;

  // Walk from lane 0 upward; the run stops at the first zero and later ones are ignored.
  always_comb begin
    ones  = '0;
    w_run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_run = w_run & bits[i];
      if (w_run) begin
        ones = ones + c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_fifo
// Purpose  : Multi-lane push / multi-lane pop FIFO on distributed RAM.
//            Up to IN_WIDTH entries enter and OUT_WIDTH entries leave per
//            cycle, always in lane order. Pointers carry a wrap bit so all
//            DEPTH slots are usable; occupancy comes from a count register.
// Revision : 1.0 - initial release
// ============================================================================
module multi_port_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  parameter int IN_WIDTH   = 2,
  parameter int OUT_WIDTH  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [IN_WIDTH-1:0]                   push_valid,
  input  logic [IN_WIDTH-1:0][DATA_WIDTH-1:0]   push_data,
  output logic                                  push_ready,
  output logic [OUT_WIDTH-1:0]                  pop_valid,
  output logic [OUT_WIDTH-1:0][DATA_WIDTH-1:0]  pop_data,
  input  logic [OUT_WIDTH-1:0]                  pop_ready,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  full,
  output logic                                  empty
);

  localparam int c_idx_w     = $clog2(DEPTH);
  localparam int c_ptr_w     = c_idx_w + 1;
  localparam int c_cnt_w     = c_idx_w + 1;
  localparam int c_in_cnt_w  = $clog2(IN_WIDTH + 1);
  localparam int c_out_cnt_w = $clog2(OUT_WIDTH + 1);

  // Storage is deliberately left unreset so it maps onto LUT RAM.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [c_ptr_w-1:0]     r_head;
  logic [c_ptr_w-1:0]     r_tail;
  logic [c_cnt_w-1:0]     r_count;

  logic [c_cnt_w-1:0]     w_free;
  logic [IN_WIDTH-1:0]    w_push_req;
  logic [IN_WIDTH-1:0]    w_wr_en;
  logic [c_in_cnt_w-1:0]  w_push_cnt;
  logic [OUT_WIDTH-1:0]   w_pop_req;
  logic [c_out_cnt_w-1:0] w_pop_cnt;
  logic [c_idx_w-1:0]     w_wr_idx [IN_WIDTH];
  logic [c_idx_w-1:0]     w_rd_idx [OUT_WIDTH];

  // Admission uses only the registered count, so a same-cycle pop never opens space.
  assign w_free     = c_cnt_w'(DEPTH) - r_count;
  assign push_ready = (w_free >= c_cnt_w'(IN_WIDTH));
  assign w_push_req = push_ready ? push_valid : '0;
  assign w_pop_req  = pop_valid & pop_ready;

  leading_ones_count #(.WIDTH(IN_WIDTH)) u_push_cnt (
    .bits (w_push_req),
    .ones (w_push_cnt)
  );

  leading_ones_count #(.WIDTH(OUT_WIDTH)) u_pop_cnt (
    .bits (w_pop_req),
    .ones (w_pop_cnt)
  );

  // Lane g writes only when it sits inside the accepted leading run.
  for (genvar g = 0; g < IN_WIDTH; g++) begin : g_wr_lane
    assign w_wr_idx[g] = r_tail[c_idx_w-1:0] + c_idx_w'(g);
    assign w_wr_en[g]  = !flush && (c_in_cnt_w'(g) < w_push_cnt);
  end

  // Read lanes expose head+g combinationally; valid while occupancy exceeds g.
  for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_rd_lane
    assign w_rd_idx[g]  = r_head[c_idx_w-1:0] + c_idx_w'(g);
    assign pop_data[g]  = r_mem[w_rd_idx[g]];
    assign pop_valid[g] = (r_count > c_cnt_w'(g));
  end

  assign count = r_count;
  assign full  = (r_count == c_cnt_w'(DEPTH));
  assign empty = (r_count == '0);

  // RAM write port: accepted lanes land at consecutive slots from tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (w_wr_en[i]) begin
        r_mem[w_wr_idx[i]] <= push_data[i];
      end
    end
  end

  // Pointer and occupancy update; flush overrides any same-cycle traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_ptr_w'(w_pop_cnt);
      r_tail  <= r_tail + c_ptr_w'(w_push_cnt);
      r_count <= r_count + c_cnt_w'(w_push_cnt) - c_cnt_w'(w_pop_cnt);
    end
  end

  // Pointer distance (wrap bit included) must always agree with the count register.
  always_comb begin
    assert (c_cnt_w'(r_tail - r_head) == r_count);
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_port_fifo
// Purpose  : Self-checking bench for multi_port_fifo (8-bit x 8 deep, 2/2 lanes).
//            Queue model holds expected contents; popped lanes are compared
//            against the queue head in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_port_fifo;

  localparam int DW = 8;
  localparam int DP = 8;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [1:0]       push_valid;
  logic [1:0][DW-1:0] push_data;
  logic             push_ready;
  logic [1:0]       pop_valid;
  logic [1:0][DW-1:0] pop_data;
  logic [1:0]       pop_ready;
  logic [3:0]       count;
  logic             full;
  logic             empty;

  multi_port_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .IN_WIDTH   (2),
    .OUT_WIDTH  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] mdl_q [$];

  typedef struct {
    logic [1:0]    pv;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    pr;
    logic          fl;
    int            exp_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Status outputs against the queue model (called at the falling edge).
  task automatic check_status();
    int sz;
    sz = mdl_q.size();
    chk("count",      32'(count),      32'(sz));
    chk("full",       32'(full),       32'(sz == DP));
    chk("empty",      32'(empty),      32'(sz == 0));
    chk("push_ready", 32'(push_ready), 32'((DP - sz) >= 2));
    chk("pop_valid",  32'(pop_valid),  32'({sz > 1, sz > 0}));
  endtask

  // One clock: check status, drive inputs, update the model, advance to next falling edge.
  task automatic cycle(input logic [1:0] pv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] pr, input logic fl);
    int sz;
    int npush;
    int npop;
    logic [DW-1:0] exp_d;
    check_status();
    push_valid   = pv;
    push_data[0] = d0;
    push_data[1] = d1;
    pop_ready    = pr;
    flush        = fl;
    sz    = mdl_q.size();
    npush = 0;
    if ((DP - sz) >= 2 && pv[0]) npush = pv[1] ? 2 : 1;
    npop = 0;
    if (sz > 0 && pr[0]) npop = (sz > 1 && pr[1]) ? 2 : 1;
    if (fl) begin
      mdl_q.delete();
    end else begin
      for (int i = 0; i < npop; i++) begin
        exp_d = mdl_q.pop_front();
        chk($sformatf("pop_data_lane%0d", i), 32'(pop_data[i]), 32'(exp_d));
      end
      if (npush > 0) mdl_q.push_back(d0);
      if (npush > 1) mdl_q.push_back(d1);
    end
    @(posedge clk);
    @(negedge clk);
    push_valid = 2'b00;
    pop_ready  = 2'b00;
    flush      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {pv, d0, d1, pr, flush, count after the edge}
    vecs[0]  = '{2'b11, 8'h11, 8'h22, 2'b00, 1'b0, 2};
    vecs[1]  = '{2'b10, 8'h33, 8'h44, 2'b00, 1'b0, 2};
    vecs[2]  = '{2'b00, 8'h00, 8'h00, 2'b10, 1'b0, 2};
    vecs[3]  = '{2'b01, 8'h33, 8'h00, 2'b01, 1'b0, 2};
    vecs[4]  = '{2'b11, 8'h44, 8'h55, 2'b11, 1'b0, 2};
    vecs[5]  = '{2'b11, 8'h66, 8'h77, 2'b00, 1'b0, 4};
    vecs[6]  = '{2'b11, 8'h88, 8'h99, 2'b00, 1'b0, 6};
    vecs[7]  = '{2'b01, 8'hAA, 8'h00, 2'b00, 1'b0, 7};
    vecs[8]  = '{2'b11, 8'hBB, 8'hCC, 2'b00, 1'b0, 7};
    vecs[9]  = '{2'b00, 8'h00, 8'h00, 2'b11, 1'b0, 5};
    vecs[10] = '{2'b11, 8'hBB, 8'hCC, 2'b01, 1'b0, 6};
    vecs[11] = '{2'b11, 8'hDD, 8'hEE, 2'b00, 1'b0, 8};
    vecs[12] = '{2'b11, 8'hF0, 8'hF1, 2'b00, 1'b0, 8};
    vecs[13] = '{2'b00, 8'h00, 8'h00, 2'b11, 1'b0, 6};

    rst          = 1'b0;
    flush        = 1'b0;
    push_valid   = 2'b00;
    push_data[0] = '0;
    push_data[1] = '0;
    pop_ready    = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_status();
    rst = 1'b1;
    @(negedge clk);

    // First push: both lanes visible one cycle later in lane order.
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].pv, vecs[i].d0, vecs[i].d1, vecs[i].pr, vecs[i].fl);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
      if (i == 0) begin
        chk("first_pop_data", 32'(pop_data), 32'(16'h2211));
        chk("first_pop_valid", 32'(pop_valid), 32'(2'b11));
      end
      if (i == 8 || i == 12) chk($sformatf("vec%0d_push_ready", i), 32'(push_ready), 32'(0));
      if (i == 12) chk("full_flag", 32'(full), 32'(1));
    end

    // Flush at count 5 with pushes and pops requested: everything discarded.
    cycle(2'b00, 8'h00, 8'h00, 2'b01, 1'b0);
    chk("pre_flush_count", 32'(count), 32'(5));
    cycle(2'b11, 8'h12, 8'h34, 2'b11, 1'b1);
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_empty", 32'(empty), 32'(1));
    chk("flush_pop_valid", 32'(pop_valid), 32'(2'b00));

    // Steady 2-in/2-out across several wraps.
    cycle(2'b11, 8'h40, 8'h41, 2'b00, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(2'b11, 8'(8'h42 + 2 * k), 8'(8'h43 + 2 * k), 2'b11, 1'b0);
      chk($sformatf("steady%0d_count", k), 32'(count), 32'(2));
    end

    // Fill to full, then show a full FIFO refuses a two-lane push.
    for (int k = 0; k < 3; k++) begin
      cycle(2'b11, 8'(8'hC0 + 2 * k), 8'(8'hC1 + 2 * k), 2'b00, 1'b0);
    end
    chk("fill_full", 32'(full), 32'(1));
    chk("fill_push_ready", 32'(push_ready), 32'(0));
    cycle(2'b11, 8'hE0, 8'hE1, 2'b00, 1'b0);
    chk("full_hold_count", 32'(count), 32'(8));
    cycle(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    chk("midstream_count", 32'(count), 32'(6));

    // Asynchronous reset between edges at count 6.
    #2;
    rst = 1'b0;
    #1;
    mdl_q.delete();
    chk("async_rst_count", 32'(count), 32'(0));
    chk("async_rst_push_ready", 32'(push_ready), 32'(1));
    chk("async_rst_empty", 32'(empty), 32'(1));
    chk("async_rst_pop_valid", 32'(pop_valid), 32'(2'b00));
    @(negedge clk);
    check_status();
    rst = 1'b1;
    @(negedge clk);
    cycle(2'b01, 8'hAA, 8'h00, 2'b00, 1'b0);
    chk("post_rst_pop_data0", 32'(pop_data[0]), 32'(8'hAA));
    chk("post_rst_pop_valid", 32'(pop_valid), 32'(2'b01));
    cycle(2'b00, 8'h00, 8'h00, 2'b01, 1'b0);
    check_status();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_port_fifo.md
MULTI_PORT_FIFO -- requirements
Module: multi_port_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 128, bits per entry.
REQ-002 Parameter DEPTH, default 8, entry count; power of two, >= max(IN_WIDTH, OUT_WIDTH).
REQ-003 Parameter IN_WIDTH, default 2, push lanes per cycle.
REQ-004 Parameter OUT_WIDTH, default 2, pop lanes per cycle.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low.
REQ-007 flush  input  1  synchronous clear of all contents.
REQ-008 push_valid  input  IN_WIDTH  per-lane write request, lane 0 oldest.
REQ-009 push_data  input  IN_WIDTH x DATA_WIDTH  per-lane write data.
REQ-010 push_ready  output  1  space for IN_WIDTH entries available.
REQ-011 pop_valid  output  OUT_WIDTH  lane i holds entry (head+i).
REQ-012 pop_data  output  OUT_WIDTH x DATA_WIDTH  lane i = entry at head+i.
REQ-013 pop_ready  input  OUT_WIDTH  per-lane consumer accept.
REQ-014 count  output  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH.
REQ-015 full / empty  output  1 each  count==DEPTH / count==0.

Function
REQ-016 Storage SHALL be distributed (LUT) RAM, unreset; full DEPTH capacity usable (pointers carry one wrap bit, no sacrificed slot).
REQ-017 push_ready SHALL be (DEPTH - count) >= IN_WIDTH, from registered count only; same-cycle pops do not raise it.
REQ-018 Accepted pushes = length of contiguous leading run of push_valid ones when push_ready=1, else 0; lanes after first zero SHALL be ignored.
REQ-019 Accepted entries SHALL be written in lane order at tail, tail advancing by accepted count modulo DEPTH.
REQ-020 pop_valid[i] SHALL equal (count > i); pop_data[i] combinational read of head+i modulo DEPTH.
REQ-021 Popped = length of contiguous leading run where pop_valid[i] & pop_ready[i]; head advances by popped modulo DEPTH.
REQ-022 count next = count + pushed - popped, same cycle, both allowed together.
REQ-023 No bypass: data pushed in cycle N first appears on pop_data in cycle N+1 (latency 1).
REQ-024 flush=1: head, tail, count cleared next edge; same-cycle pushes and pops discarded; flush wins over all.
REQ-025 pop_data lanes with pop_valid=0 are don't-care; consumer SHALL NOT sample them.
REQ-026 Wrap: read/write indices spanning the DEPTH boundary SHALL wrap without stall or reorder.

Reset
REQ-027 rst low SHALL asynchronously clear head, tail, count: count=0, empty=1, full=0, pop_valid=0, push_ready=1.
REQ-028 Reset mid-operation SHALL discard all contents; RAM content not cleared; first push after release lands at index 0.

Structure
REQ-029 No shared package entries; all widths derived locally from parameters.
REQ-030 One sub-module, leading_ones_count (width parameter), used for both push and pop lane counting.
REQ-031 Pointers SHALL be $clog2(DEPTH)+1 bits; full/empty from count register, not pointer compare.

Verification (DATA_WIDTH=8, DEPTH=8, IN_WIDTH=2, OUT_WIDTH=2)
REQ-032 Reset, push 0x11/0x22 both lanes -> next cycle count=2, pop_valid=11, pop_data={0x22,0x11}.
REQ-033 Fill 8 entries, no pops -> count=8, full=1, push_ready=0; push_valid=11 accepts nothing; count stays 8 at count=7 also push_ready=0.
REQ-034 push_valid=10 (lane 0 low) -> zero accepted; pop_ready=10 with 2 valid -> zero popped, count unchanged.
REQ-035 Steady push 2/pop 2 for 20 cycles from count=2 -> count stays 2, output sequence strictly in push order across wraps.
REQ-036 count=5, flush with push_valid=11 and pop_ready=11 -> next cycle count=0, empty=1, pop_valid=00.
REQ-037 rst low mid-stream at count=6, asynchronously between edges -> count=0, push_ready=1 immediately; after release push 0xAA -> pop_data[0]=0xAA next cycle.
